// File: rtl/term_tile_frame_loader.sv
// Configuration-frame loader for a column of fabric tiles: decodes frame headers from a
// 32-bit word stream and drives FrameData plus a one-hot FrameStrobe. Optional checksum: FRAME_LOADER_CHECKSUM_EN.
module term_tile_frame_loader #(
    parameter int FRAME_BITS     = 32,
    parameter int FRAMES_PER_COL = 20,
    parameter int COLS           = 4
) (
    input  logic                           CLK,
    input  logic                           reset,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [31:0]                    s_data,
    output logic [FRAME_BITS-1:0]          FrameData,
    output logic [COLS*FRAMES_PER_COL-1:0] FrameStrobe,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [2:0]                     state_dbg
);

    localparam int SW = COLS * FRAMES_PER_COL;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [7:0] SYNC = 8'hFA;

`ifdef FRAME_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STROBE = 3'd2,
        DRAIN  = 3'd3,
        CHECK  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STROBE = 3'd2,
        DRAIN  = 3'd3
    } state_t;
`endif

    state_t          state_q, state_n;
    logic [CW-1:0]   col_q, col_n;
    logic [7:0]      frame_q, frame_n;
    logic [7:0]      rem_q, rem_n;
    logic [31:0]     data_n;
    logic [SW-1:0]   strobe_q, strobe_n;
    logic            done_n, err_n;
`ifdef FRAME_LOADER_CHECKSUM_EN
    logic [31:0]     csum_q, csum_n;
`endif

    // A word moves only on a rising CLK with s_valid && s_ready; s_ready is registered
    // and drops only for the single STROBE cycle, so s_data is never looked at while it is low.
    logic accept;
    assign accept = s_valid && s_ready;

    logic [7:0] hdr_sync, hdr_col, hdr_start, hdr_n;
    logic       hdr_in_range;
    assign hdr_sync  = s_data[31:24];
    assign hdr_col   = s_data[23:16];
    assign hdr_start = s_data[15:8];
    assign hdr_n     = s_data[7:0];
    // 9-bit sum so start+N cannot wrap back into range
    assign hdr_in_range = (hdr_col < 8'(COLS)) &&
                          (({1'b0, hdr_start} + {1'b0, hdr_n}) <= 9'(FRAMES_PER_COL));

    logic [15:0]   strobe_idx;
    logic [SW-1:0] strobe_onehot;
    assign strobe_idx    = 16'(col_q) * 16'(FRAMES_PER_COL) + 16'(frame_q);
    assign strobe_onehot = {{(SW-1){1'b0}}, 1'b1} << strobe_idx;

    always_comb begin
        state_n  = state_q;
        col_n    = col_q;
        frame_n  = frame_q;
        rem_n    = rem_q;
        data_n   = FrameData;
        strobe_n = '0;
        done_n   = 1'b0;
        err_n    = err;
`ifdef FRAME_LOADER_CHECKSUM_EN
        csum_n   = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hdr_sync != SYNC) begin
                        err_n = 1'b1;
                    end else if (hdr_n == 8'd0) begin
                        done_n = 1'b1;
                    end else if (!hdr_in_range) begin
                        err_n   = 1'b1;
                        rem_n   = hdr_n;
                        state_n = DRAIN;
`ifdef FRAME_LOADER_CHECKSUM_EN
                        csum_n  = '0;
`endif
                    end else begin
                        col_n   = hdr_col[CW-1:0];
                        frame_n = hdr_start;
                        rem_n   = hdr_n;
                        state_n = LOAD;
`ifdef FRAME_LOADER_CHECKSUM_EN
                        csum_n  = '0;
`endif
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    data_n   = s_data;
                    strobe_n = strobe_onehot;
                    state_n  = STROBE;
`ifdef FRAME_LOADER_CHECKSUM_EN
                    csum_n   = csum_q ^ s_data;
`endif
                end
            end
            STROBE: begin
                frame_n = frame_q + 8'd1;
                rem_n   = rem_q - 8'd1;
                if (rem_q == 8'd1) begin
`ifdef FRAME_LOADER_CHECKSUM_EN
                    state_n = CHECK;
`else
                    done_n  = 1'b1;
                    state_n = IDLE;
`endif
                end else begin
                    state_n = LOAD;
                end
            end
            DRAIN: begin
                if (accept) begin
                    rem_n = rem_q - 8'd1;
`ifdef FRAME_LOADER_CHECKSUM_EN
                    csum_n = csum_q ^ s_data;
                    if (rem_q == 8'd1) state_n = CHECK;
`else
                    if (rem_q == 8'd1) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
`endif
                end
            end
`ifdef FRAME_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    if (s_data != csum_q) err_n = 1'b1;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= IDLE;
            col_q     <= '0;
            frame_q   <= '0;
            rem_q     <= '0;
            FrameData <= '0;
            strobe_q  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            s_ready   <= 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_n;
            col_q     <= col_n;
            frame_q   <= frame_n;
            rem_q     <= rem_n;
            FrameData <= data_n;
            strobe_q  <= strobe_n;
            done      <= done_n;
            err       <= err_n;
            s_ready   <= (state_n != STROBE);
`ifdef FRAME_LOADER_CHECKSUM_EN
            csum_q    <= csum_n;
`endif
        end
    end

    // Gating with reset keeps a strobe already registered from reaching the tiles in a reset cycle
    assign FrameStrobe = reset ? '0 : strobe_q;
    assign busy        = (state_q != IDLE);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_term_tile_frame_loader.sv
// Directed bench for term_tile_frame_loader: linear sequence of steps with hand-computed expectations.
module tb_term_tile_frame_loader;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic [31:0] FrameData;
    logic [79:0] FrameStrobe;
    logic        busy, done, err;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int cnt0;
    logic [31:0] prev_data;

    term_tile_frame_loader dut (
        .CLK(CLK), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy), .done(done),
        .err(err), .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offer one word and return just after the edge that accepts it
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && n < 40) begin
            tick();
            n++;
        end
        check("accept_timeout", (n < 40), 1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    function automatic logic [79:0] bit_at(input int i);
        logic [79:0] one;
        one = 80'd1;
        return one << i;
    endfunction

    always @(negedge CLK) begin
        if (FrameStrobe != '0) begin
            strobe_cnt++;
            check("strobe_onehot", $countones(FrameStrobe), 1);
            check("ready_low_in_strobe", s_ready, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] words [4];
        int          gaps [4];
        words = '{32'h0000_0001, 32'h8000_0000, 32'h5A5A_A5A5, 32'hFFFF_0000};
        gaps  = '{2, 0, 3, 1};

        tick();
        tick();
        check("rst_ready", s_ready, 0);
        check("rst_data", FrameData, 0);
        check("rst_strobe", FrameStrobe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_state", state_dbg, 0);
        reset = 1'b0;
        tick();
        check("ready_after_reset", s_ready, 1);

`ifdef FRAME_LOADER_CHECKSUM_EN
        send(32'hFA00_0002);
        send(32'h0000_00F0);
        check("cs_strobe0", FrameStrobe, bit_at(0));
        tick();
        send(32'h0000_000F);
        check("cs_strobe1", FrameStrobe, bit_at(1));
        tick();
        check("cs_wait_busy", busy, 1);
        check("cs_wait_done", done, 0);
        send(32'h0000_00FF);
        check("cs_good_done", done, 1);
        check("cs_good_err", err, 0);
        send(32'hFA00_0002);
        send(32'h0000_00F0);
        tick();
        send(32'h0000_000F);
        tick();
        send(32'h0000_0000);
        check("cs_bad_done", done, 1);
        check("cs_bad_err", err, 1);
`else
        // two-frame packet into column 1 starting at frame 3
        send(32'hFA01_0302);
        check("t1_busy_hdr", busy, 1);
        check("t1_nostrobe_hdr", FrameStrobe, 0);
        send(32'hDEADBEEF);
        check("t1_strobe23", FrameStrobe, bit_at(23));
        check("t1_data0", FrameData, 32'hDEADBEEF);
        check("t1_ready_strobe", s_ready, 0);
        tick();
        check("t1_strobe_clear", FrameStrobe, 0);
        check("t1_ready_load", s_ready, 1);
        send(32'h12345678);
        check("t1_strobe24", FrameStrobe, bit_at(24));
        check("t1_data1", FrameData, 32'h12345678);
        check("t1_done_early", done, 0);
        tick();
        check("t1_done", done, 1);
        check("t1_busy_end", busy, 0);
        check("t1_err", err, 0);
        tick();
        check("t1_done_pulse", done, 0);
        check("t1_data_hold", FrameData, 32'h12345678);

        send(32'hFA00_0500);
        check("n0_done", done, 1);
        check("n0_busy", busy, 0);
        check("n0_err", err, 0);
        tick();
        check("n0_done_pulse", done, 0);

        send(32'hAB00_0001);
        check("sync_err", err, 1);
        check("sync_busy", busy, 0);
        check("sync_ready", s_ready, 1);
        send(32'hFA00_0001);
        check("sync_next_busy", busy, 1);
        send(32'hCAFEF00D);
        check("sync_next_strobe0", FrameStrobe, bit_at(0));
        check("sync_next_data", FrameData, 32'hCAFEF00D);
        tick();
        check("sync_next_done", done, 1);

        do_reset();
        check("err_cleared", err, 0);
        cnt0 = strobe_cnt;
        send(32'hFA00_1305);
        check("rng_err", err, 1);
        check("rng_state_drain", state_dbg, 3);
        for (int i = 0; i < 5; i++) begin
            send(32'h1111_0000 + 32'(i));
            check("rng_data_held", FrameData, 0);
            if (i < 4) check("rng_done_early", done, 0);
        end
        check("rng_done", done, 1);
        check("rng_busy", busy, 0);
        check("rng_ready", s_ready, 1);
        check("rng_no_strobe", strobe_cnt, cnt0);

        // four frames in column 2 from frame 4, with stalls on the source side
        cnt0 = strobe_cnt;
        prev_data = FrameData;
        send(32'hFA02_0404);
        for (int i = 0; i < 4; i++) begin
            s_data = 32'hFFFF_FFFF;
            for (int g = 0; g < gaps[i]; g++) begin
                tick();
                check("bp_gap_strobe", FrameStrobe, 0);
                check("bp_gap_busy", busy, 1);
                check("bp_gap_data", FrameData, prev_data);
            end
            send(words[i]);
            check("bp_strobe", FrameStrobe, bit_at(44 + i));
            check("bp_data", FrameData, words[i]);
            prev_data = words[i];
            tick();
            check("bp_strobe_one_cycle", FrameStrobe, 0);
        end
        check("bp_done", done, 1);
        check("bp_strobe_count", strobe_cnt - cnt0, 4);

        cnt0 = strobe_cnt;
        send(32'hFA00_0102);
        send(32'hAAAA_5555);
        reset = 1'b1;
        #1;
        check("mid_rst_strobe_gated", FrameStrobe, 0);
        tick();
        check("mid_rst_ready", s_ready, 0);
        check("mid_rst_data", FrameData, 0);
        check("mid_rst_strobe", FrameStrobe, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_state", state_dbg, 0);
        reset = 1'b0;
        tick();
        check("mid_rst_ready_back", s_ready, 1);
        send(32'hFA03_0001);
        check("post_rst_busy", busy, 1);
        send(32'h0BAD_F00D);
        check("post_rst_strobe60", FrameStrobe, bit_at(60));
        tick();
        check("post_rst_done", done, 1);
        check("post_rst_strobe_count", strobe_cnt - cnt0, 1);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
